regfile_seq_ctrl: RTL and testbench

//  Initiator that drives the 64x32 regfile read/write ports to fill it with a

---
 rtl/regfile_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_regfile_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl: sequencer that fills a regfile with a Fibonacci-style
// series. It reads reg[idx] and reg[idx+1] through the regfile read port and
// writes their sum to reg[idx+2], from the two seeds at START_ADDR up to
// LAST_ADDR. Each element takes three cycles (RD_A, RD_B, WR). A one-cycle
// done pulse marks the end of a run. overflow is sticky for the whole run.
module regfile_seq_ctrl #(
  parameter int AW         = 6,
  parameter int DW         = 32,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 63
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] rAddr1,
  input  logic [DW-1:0] rDout1,
  output logic [AW-1:0] wAddr,
  output logic [DW-1:0] wDin,
  output logic          wEna,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [AW-1:0] START_A = AW'(START_ADDR);
  localparam logic [AW-1:0] LAST_A  = AW'(LAST_ADDR);

  // Full-width add; the extra top bit is the carry out of the DW-bit sum.
  function automatic logic [DW:0] add_carry(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          ovf_q, ovf_d;

  logic [DW:0]   sum_s;
  logic [AW-1:0] idx_p1_s;
  logic [AW-1:0] idx_p2_s;

  assign sum_s    = add_carry(a_q, b_q);
  assign idx_p1_s = idx_q + AW'(1);
  assign idx_p2_s = idx_q + AW'(2);

  // Next-state logic: state walk, operand capture and sticky overflow.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = START_A;
          ovf_d   = 1'b0;
          state_d = S_RD_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_A: begin
        a_d     = rDout1;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        b_d     = rDout1;
        state_d = S_WR;
      end
      S_WR: begin
        if (sum_s[DW]) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (idx_p2_s == LAST_A) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_p1_s;
          state_d = S_RD_A;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= {AW{1'b0}};
      a_q     <= {DW{1'b0}};
      b_q     <= {DW{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
    end
  end

  // Moore output decode from the registered state, idx, a and b.
  always_comb begin
    rAddr1 = {AW{1'b0}};
    wAddr  = {AW{1'b0}};
    wDin   = {DW{1'b0}};
    wEna   = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_RD_A: begin
        rAddr1 = idx_q;
        busy   = 1'b1;
      end
      S_RD_B: begin
        rAddr1 = idx_p1_s;
        busy   = 1'b1;
      end
      S_WR: begin
        wAddr = idx_p2_s;
        wDin  = sum_s[DW-1:0];
        wEna  = 1'b1;
        busy  = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Bench for regfile_seq_ctrl: three controllers (LAST_ADDR 63, 5 and 2), each
// beside its own behavioural regfile. Expected writes are computed from the
// model regfile when a run starts, queued, and popped on every WR cycle.
module tb_regfile_seq_ctrl;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start  [3];
  logic [5:0]  raddr  [3];
  logic [31:0] rdout  [3];
  logic [5:0]  waddr  [3];
  logic [31:0] wdin   [3];
  logic        wena   [3];
  logic        busy   [3];
  logic        done   [3];
  logic        ovf    [3];

  logic [31:0] rf [3][64];
  int          last_a [3];

  exp_t        sb[$];
  int          n_cmp;
  int          n_err;
  logic        pend;
  logic [5:0]  pend_addr;
  logic [31:0] pend_data;
  int          fo;

  regfile_seq_ctrl u_dut63 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .rAddr1(raddr[0]), .rDout1(rdout[0]),
    .wAddr(waddr[0]), .wDin(wdin[0]), .wEna(wena[0]), .busy(busy[0]), .done(done[0]),
    .overflow(ovf[0]));

  regfile_seq_ctrl #(.LAST_ADDR(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .rAddr1(raddr[1]), .rDout1(rdout[1]),
    .wAddr(waddr[1]), .wDin(wdin[1]), .wEna(wena[1]), .busy(busy[1]), .done(done[1]),
    .overflow(ovf[1]));

  regfile_seq_ctrl #(.LAST_ADDR(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .rAddr1(raddr[2]), .rDout1(rdout[2]),
    .wAddr(waddr[2]), .wDin(wdin[2]), .wEna(wena[2]), .busy(busy[2]), .done(done[2]),
    .overflow(ovf[2]));

  // Combinational regfile read ports.
  assign rdout[0] = rf[0][raddr[0]];
  assign rdout[1] = rf[1][raddr[1]];
  assign rdout[2] = rf[2][raddr[2]];

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Regfile reset contents: seeds 2, 2, everything else zero.
  task automatic rf_reset(input int k);
    for (int i = 0; i < 64; i++) rf[k][i] = 32'd0;
    rf[k][0] = 32'd2;
    rf[k][1] = 32'd2;
  endtask

  // One clock: commit a write seen in the previous cycle at the edge, then
  // sample instance k at the falling edge.
  task automatic cycle(input int k);
    @(posedge clk);
    if (pend) rf[k][pend_addr] = pend_data;
    pend = 1'b0;
    @(negedge clk);
    if (wena[k] === 1'b1) begin
      pend      = 1'b1;
      pend_addr = waddr[k];
      pend_data = wdin[k];
    end
  endtask

  // One full run on instance k with a cycle-by-cycle check of every output.
  // first_ovf returns the address whose write first set overflow (or -1).
  task automatic run(input int k, input bit hold, output int first_ovf);
    logic [31:0] m [64];
    logic [63:0] sum;
    int          n;
    int          e;
    int          ph;
    int          idx;
    logic        ovf_exp;
    exp_t        x;
    exp_t        got;
    n         = last_a[k] - 1;
    first_ovf = -1;
    for (int i = 0; i < 64; i++) m[i] = rf[k][i];
    for (int i = 0; i < n; i++) begin
      sum      = {32'd0, m[i]} + {32'd0, m[i+1]};
      m[i+2]   = sum[31:0];
      x.addr   = 6'(i + 2);
      x.data   = sum[31:0];
      x.ovf    = sum[32];
      sb.push_back(x);
    end
    ovf_exp  = 1'b0;
    start[k] = 1'b1;
    for (int c = 1; c <= 3 * n + 3; c++) begin
      cycle(k);
      if (!hold && c == 1) start[k] = 1'b0;
      if (hold && c == 3 * n + 1) start[k] = 1'b0;
      check("overflow", 64'(ovf[k]), 64'(ovf_exp));
      if (c <= 3 * n) begin
        e   = (c - 1) / 3;
        ph  = (c - 1) % 3;
        idx = e;
        check("busy_run", 64'(busy[k]), 64'd1);
        check("done_run", 64'(done[k]), 64'd0);
        check("wena_phase", 64'(wena[k]), (ph == 2) ? 64'd1 : 64'd0);
        if (ph == 0) check("raddr_rd_a", 64'(raddr[k]), 64'(idx));
        if (ph == 1) check("raddr_rd_b", 64'(raddr[k]), 64'(idx + 1));
        if (ph == 2) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
          end else begin
            got = sb.pop_front();
            check("waddr", 64'(waddr[k]), 64'(got.addr));
            check("wdin", 64'(wdin[k]), 64'(got.data));
            if (got.ovf && !ovf_exp) first_ovf = int'(got.addr);
            ovf_exp = ovf_exp | got.ovf;
          end
        end
      end else if (c == 3 * n + 1) begin
        check("done_pulse", 64'(done[k]), 64'd1);
        check("busy_done", 64'(busy[k]), 64'd0);
        check("wena_done", 64'(wena[k]), 64'd0);
      end else begin
        check("done_idle", 64'(done[k]), 64'd0);
        check("busy_idle", 64'(busy[k]), 64'd0);
        check("wena_idle", 64'(wena[k]), 64'd0);
      end
    end
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  // Directed test sequence.
  initial begin
    n_cmp     = 0;
    n_err     = 0;
    pend      = 1'b0;
    pend_addr = 6'd0;
    pend_data = 32'd0;
    last_a[0] = 63;
    last_a[1] = 5;
    last_a[2] = 2;
    rst_n     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      rf_reset(k);
    end

    // Reset values while rst_n is held low.
    #12;
    check("rst_raddr", 64'(raddr[0]), 64'd0);
    check("rst_waddr", 64'(waddr[0]), 64'd0);
    check("rst_wdin", 64'(wdin[0]), 64'd0);
    check("rst_wena", 64'(wena[0]), 64'd0);
    check("rst_busy", 64'(busy[0]), 64'd0);
    check("rst_done", 64'(done[0]), 64'd0);
    check("rst_ovf", 64'(ovf[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0);

    // Short run to reg5 from seeds 2, 2.
    run(1, 1'b0, fo);
    check("t1_reg2", 64'(rf[1][2]), 64'd4);
    check("t1_reg3", 64'(rf[1][3]), 64'd6);
    check("t1_reg4", 64'(rf[1][4]), 64'd10);
    check("t1_reg5", 64'(rf[1][5]), 64'd16);
    check("t1_no_ovf", 64'(fo + 1), 64'd0);

    // Reset dropped during the WR of reg3: immediate abort, no write.
    rf_reset(1);
    start[1] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cycle(1);
      if (c == 1) start[1] = 1'b0;
    end
    check("t4_wena_before", 64'(wena[1]), 64'd1);
    check("t4_waddr_before", 64'(waddr[1]), 64'd3);
    rst_n = 1'b0;
    pend  = 1'b0;
    #1;
    check("t4_wena_abort", 64'(wena[1]), 64'd0);
    check("t4_busy_abort", 64'(busy[1]), 64'd0);
    check("t4_waddr_abort", 64'(waddr[1]), 64'd0);
    check("t4_done_abort", 64'(done[1]), 64'd0);
    cycle(1);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle(1);
      check("t4_no_write", 64'(wena[1]), 64'd0);
      check("t4_idle", 64'(busy[1]), 64'd0);
    end
    check("t4_reg2_kept", 64'(rf[1][2]), 64'd4);
    check("t4_reg3_unwritten", 64'(rf[1][3]), 64'd0);

    // Single-element run that overflows.
    rf[2][0] = 32'hFFFF_FFFF;
    rf[2][1] = 32'h0000_0001;
    run(2, 1'b0, fo);
    check("t5_reg2", 64'(rf[2][2]), 64'd0);
    check("t5_ovf", 64'(ovf[2]), 64'd1);
    check("t5_first_ovf", 64'(fo), 64'd2);

    // Full default run with start held high throughout: one run only.
    run(0, 1'b1, fo);
    check("t2_reg45", 64'(rf[0][45]), 64'd3672623806);
    check("t2_first_ovf", 64'(fo), 64'd46);
    check("t2_ovf_sticky", 64'(ovf[0]), 64'd1);
    for (int c = 0; c < 5; c++) begin
      cycle(0);
      check("t3_no_rerun", 64'(busy[0]), 64'd0);
    end

    // A new run from IDLE clears overflow on its start edge.
    run(0, 1'b0, fo);
    check("t3_reg45_again", 64'(rf[0][45]), 64'd3672623806);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
